avalon_cmd_bridge: RTL and testbench

Pipelined Avalon-MM bridge between the custom logic master port and the SDRAM controller slave.
- Decouples the custom master's one-request-at-a-time FSM from SDRAM controller stalls.
- Buffers up to CMD_DEPTH commands in a FIFO.
- Tracks up to MAX_PENDING outstanding reads and returns read data in order.
- Reports protocol errors on two sticky status outputs.

---
 rtl/avalon_cmd_bridge_if.sv | 24 ++
 rtl/avalon_cmd_bridge.sv | 163 ++++++++++++++++
 tb/tb_avalon_cmd_bridge.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/avalon_cmd_bridge_if.sv
// Avalon-MM command/read-return bundle shared by the upstream and downstream
// sides of avalon_cmd_bridge.
interface avalon_cmd_bridge_if #(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32
);
  logic [ADDRESSWIDTH-1:0] address;
  logic [DATAWIDTH-1:0]    writedata;
  logic                    write;
  logic                    read;
  logic                    waitrequest;
  logic [DATAWIDTH-1:0]    readdata;
  logic                    readdatavalid;

  modport master (
    output address, writedata, write, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, write, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avalon_cmd_bridge.sv
// Pipelined Avalon-MM bridge: command FIFO towards the SDRAM controller,
// in-order read return with an outstanding-read limit and sticky error flags.
module avalon_cmd_bridge #(
  parameter int ADDRESSWIDTH = 26,
  parameter int DATAWIDTH    = 32,
  parameter int CMD_DEPTH    = 4,
  parameter int MAX_PENDING  = 4
) (
  input  logic                clk,
  input  logic                reset,
  avalon_cmd_bridge_if.slave  s,
  avalon_cmd_bridge_if.master m,
  output logic [3:0]          pending,
  output logic                proto_err,
  output logic                spurious_err
);

  localparam int IW = $clog2(CMD_DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic {M_IDLE = 1'b0, M_ISSUE = 1'b1} state_e;

  logic [ADDRESSWIDTH-1:0] addr_mem_q [CMD_DEPTH];
  logic [DATAWIDTH-1:0]    data_mem_q [CMD_DEPTH];
  logic                    isw_mem_q  [CMD_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;

  state_e                  state_q;
  logic [ADDRESSWIDTH-1:0] m_address_q;
  logic [DATAWIDTH-1:0]    m_writedata_q;
  logic                    m_read_q, m_write_q;

  logic [DATAWIDTH-1:0]    s_readdata_q;
  logic                    s_readdatavalid_q;
  logic [3:0]              pending_q, pending_d;
  logic                    proto_err_q, spurious_err_q;

  logic fifo_empty, fifo_full, stall, accept, acc_read;
  logic issue_free, pop, bypass, push, ret_ok, load;
  logic [ADDRESSWIDTH-1:0] next_addr;
  logic [DATAWIDTH-1:0]    next_data;
  logic                    next_isw;

  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[IW] != rd_ptr_q[IW]) && (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]);
    stall      = fifo_full | (s.read & (pending_q >= 4'(MAX_PENDING)));
    accept     = (s.read | s.write) & ~stall;
    // A simultaneous read+write is carried as a write; the read is dropped.
    acc_read   = accept & s.read & ~s.write;
    issue_free = (state_q == M_IDLE) | ~m.waitrequest;
    pop        = issue_free & ~fifo_empty;
    // An empty FIFO is skipped so a fresh command reaches m_* one cycle later.
    bypass     = issue_free & fifo_empty & accept;
    push       = accept & ~bypass;
    load       = pop | bypass;
    ret_ok     = m.readdatavalid & (pending_q != 4'd0);
    if (pop) begin
      next_addr = addr_mem_q[rd_ptr_q[IW-1:0]];
      next_data = data_mem_q[rd_ptr_q[IW-1:0]];
      next_isw  = isw_mem_q[rd_ptr_q[IW-1:0]];
    end else begin
      next_addr = s.address;
      next_data = s.writedata;
      next_isw  = s.write;
    end
    if (acc_read && !ret_ok) begin
      pending_d = pending_q + 4'd1;
    end else if (!acc_read && ret_ok) begin
      pending_d = pending_q - 4'd1;
    end else begin
      pending_d = pending_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q[IW-1:0]] <= s.address;
      data_mem_q[wr_ptr_q[IW-1:0]] <= s.writedata;
      isw_mem_q[wr_ptr_q[IW-1:0]]  <= s.write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= M_IDLE;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
    end else begin
      case (state_q)
        M_IDLE: begin
          if (load) begin
            state_q       <= M_ISSUE;
            m_address_q   <= next_addr;
            m_writedata_q <= next_data;
            m_write_q     <= next_isw;
            m_read_q      <= ~next_isw;
          end
        end
        M_ISSUE: begin
          // Command stays frozen on the bus until the slave drops waitrequest.
          if (!m.waitrequest) begin
            if (load) begin
              m_address_q   <= next_addr;
              m_writedata_q <= next_data;
              m_write_q     <= next_isw;
              m_read_q      <= ~next_isw;
            end else begin
              state_q   <= M_IDLE;
              m_write_q <= 1'b0;
              m_read_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= M_IDLE;
          m_write_q <= 1'b0;
          m_read_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_readdata_q      <= '0;
      s_readdatavalid_q <= 1'b0;
      pending_q         <= 4'd0;
      proto_err_q       <= 1'b0;
      spurious_err_q    <= 1'b0;
    end else begin
      s_readdatavalid_q <= ret_ok;
      if (ret_ok) s_readdata_q <= m.readdata;
      pending_q <= pending_d;
      if (s.read && s.write) proto_err_q <= 1'b1;
      if (m.readdatavalid && (pending_q == 4'd0)) spurious_err_q <= 1'b1;
    end
  end

  assign s.waitrequest   = stall;
  assign s.readdata      = s_readdata_q;
  assign s.readdatavalid = s_readdatavalid_q;
  assign m.address       = m_address_q;
  assign m.writedata     = m_writedata_q;
  assign m.write         = m_write_q;
  assign m.read          = m_read_q;
  assign pending         = pending_q;
  assign proto_err       = proto_err_q;
  assign spurious_err    = spurious_err_q;

endmodule

// File: tb/tb_avalon_cmd_bridge.sv
// Directed self-checking bench for avalon_cmd_bridge (28-bit addresses so the
// 0x0800_xxxx test addresses are representable).
module tb_avalon_cmd_bridge;
  localparam int AW = 28;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] pending;
  logic proto_err, spurious_err;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  avalon_cmd_bridge_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) s_if ();
  avalon_cmd_bridge_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) m_if ();

  avalon_cmd_bridge #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .CMD_DEPTH(4), .MAX_PENDING(4)) dut (
    .clk(clk), .reset(reset), .s(s_if), .m(m_if),
    .pending(pending), .proto_err(proto_err), .spurious_err(spurious_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    s_if.address = '0; s_if.writedata = '0; s_if.write = 1'b0; s_if.read = 1'b0;
    m_if.waitrequest = 1'b0; m_if.readdata = '0; m_if.readdatavalid = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    total++; if (m_if.write !== 1'b0) $display("FAIL rst_m_write got %b exp 0", m_if.write); else passed++;
    total++; if (m_if.read !== 1'b0) $display("FAIL rst_m_read got %b exp 0", m_if.read); else passed++;
    total++; if (m_if.address !== 28'h0) $display("FAIL rst_m_address got %h exp 0", m_if.address); else passed++;
    total++; if (s_if.readdata !== 32'h0) $display("FAIL rst_s_readdata got %h exp 0", s_if.readdata); else passed++;
    total++; if (s_if.readdatavalid !== 1'b0) $display("FAIL rst_s_rdv got %b exp 0", s_if.readdatavalid); else passed++;
    total++; if (s_if.waitrequest !== 1'b0) $display("FAIL rst_s_wait got %b exp 0", s_if.waitrequest); else passed++;
    total++; if (pending !== 4'd0) $display("FAIL rst_pending got %0d exp 0", pending); else passed++;
    total++; if ({proto_err, spurious_err} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {proto_err, spurious_err}); else passed++;
  endtask

  task automatic test_single_write;
    s_if.address = 28'h800_0000; s_if.writedata = 32'hF00B_F00B; s_if.write = 1'b1;
    #1;
    total++; if (s_if.waitrequest !== 1'b0) $display("FAIL wr_accept got wait=%b exp 0", s_if.waitrequest); else passed++;
    tick();
    total++; if (m_if.write !== 1'b1) $display("FAIL wr_m_write got %b exp 1", m_if.write); else passed++;
    total++; if (m_if.read !== 1'b0) $display("FAIL wr_m_read got %b exp 0", m_if.read); else passed++;
    total++; if (m_if.address !== 28'h800_0000) $display("FAIL wr_m_address got %h exp 8000000", m_if.address); else passed++;
    total++; if (m_if.writedata !== 32'hF00B_F00B) $display("FAIL wr_m_writedata got %h exp f00bf00b", m_if.writedata); else passed++;
    s_if.write = 1'b0;
    tick();
    total++; if (m_if.write !== 1'b0) $display("FAIL wr_one_cycle got %b exp 0", m_if.write); else passed++;
    total++; if (pending !== 4'd0) $display("FAIL wr_pending got %0d exp 0", pending); else passed++;
  endtask

  task automatic test_reads;
    // per-cycle tables: issued-address index (-1 none), pending, m_readdatavalid data (0 none)
    int         exp_ma   [12] = '{-1, 0, 1, 2, 3, -1, 4, -1, -1, -1, -1, -1};
    logic [3:0] exp_pend [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd0, 4'd0};
    logic [31:0] rdv_in  [12] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44,
                                  32'h0, 32'h55, 32'h0, 32'h0};
    for (int k = 0; k < 12; k++) begin
      logic [31:0] exp_sd;
      logic [27:0] exp_addr;
      exp_sd = (k > 0) ? rdv_in[k-1] : 32'h0;
      exp_addr = 28'h800_0000 + 28'(4 * exp_ma[k]);
      total++; if (m_if.read !== (exp_ma[k] >= 0)) $display("FAIL rd_m_read c%0d got %b", k, m_if.read); else passed++;
      if (exp_ma[k] >= 0) begin
        total++; if (m_if.address !== exp_addr) $display("FAIL rd_m_address c%0d got %h exp %h", k, m_if.address, exp_addr); else passed++;
      end
      total++; if (pending !== exp_pend[k]) $display("FAIL rd_pending c%0d got %0d exp %0d", k, pending, exp_pend[k]); else passed++;
      total++; if (s_if.readdatavalid !== (exp_sd != 32'h0)) $display("FAIL rd_s_rdv c%0d got %b", k, s_if.readdatavalid); else passed++;
      if (exp_sd != 32'h0) begin
        total++; if (s_if.readdata !== exp_sd) $display("FAIL rd_s_readdata c%0d got %h exp %h", k, s_if.readdata, exp_sd); else passed++;
      end
      s_if.read = (k <= 5);
      s_if.address = 28'h800_0000 + 28'(4 * ((k <= 4) ? k : 4));
      m_if.readdatavalid = (rdv_in[k] != 32'h0);
      m_if.readdata = rdv_in[k];
      #1;
      total++; if (s_if.waitrequest !== (k == 4)) $display("FAIL rd_s_wait c%0d got %b exp %b", k, s_if.waitrequest, (k == 4)); else passed++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_stall;
    for (int k = 0; k < 18; k++) begin
      int idx;
      logic [27:0] exp_addr;
      idx = (k == 0 || k == 17) ? -1 : ((k <= 11) ? 0 : k - 11);
      exp_addr = 28'h000_0100 + 28'(4 * idx);
      total++; if (m_if.write !== (idx >= 0)) $display("FAIL st_m_write c%0d got %b", k, m_if.write); else passed++;
      if (idx >= 0) begin
        total++; if (m_if.address !== exp_addr) $display("FAIL st_m_address c%0d got %h exp %h", k, m_if.address, exp_addr); else passed++;
        total++; if (m_if.writedata !== 32'hA0 + 32'(idx)) $display("FAIL st_m_writedata c%0d got %h exp %h", k, m_if.writedata, 32'hA0 + 32'(idx)); else passed++;
      end
      s_if.write = (k <= 12);
      s_if.address = 28'h000_0100 + 28'(4 * ((k <= 5) ? k : 5));
      s_if.writedata = 32'hA0 + 32'((k <= 5) ? k : 5);
      m_if.waitrequest = (k <= 10);
      #1;
      total++; if (s_if.waitrequest !== (k >= 5 && k <= 11)) $display("FAIL st_s_wait c%0d got %b", k, s_if.waitrequest); else passed++;
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_spurious;
    m_if.readdatavalid = 1'b1; m_if.readdata = 32'hDEAD_BEEF;
    tick();
    m_if.readdatavalid = 1'b0; m_if.readdata = 32'h0;
    total++; if (s_if.readdatavalid !== 1'b0) $display("FAIL sp_s_rdv got %b exp 0", s_if.readdatavalid); else passed++;
    total++; if (spurious_err !== 1'b1) $display("FAIL sp_flag got %b exp 1", spurious_err); else passed++;
    total++; if (s_if.readdata !== 32'h55) $display("FAIL sp_readdata got %h exp 55", s_if.readdata); else passed++;
    total++; if (pending !== 4'd0) $display("FAIL sp_pending got %0d exp 0", pending); else passed++;
    tick(); tick();
    total++; if (spurious_err !== 1'b1) $display("FAIL sp_sticky got %b exp 1", spurious_err); else passed++;
  endtask

  task automatic test_proto;
    total++; if (proto_err !== 1'b0) $display("FAIL pe_before got %b exp 0", proto_err); else passed++;
    s_if.address = 28'h800_0010; s_if.writedata = 32'h5; s_if.write = 1'b1; s_if.read = 1'b1;
    tick();
    clear_inputs();
    total++; if (m_if.write !== 1'b1) $display("FAIL pe_m_write got %b exp 1", m_if.write); else passed++;
    total++; if (m_if.read !== 1'b0) $display("FAIL pe_m_read got %b exp 0", m_if.read); else passed++;
    total++; if (m_if.address !== 28'h800_0010) $display("FAIL pe_m_address got %h exp 8000010", m_if.address); else passed++;
    total++; if (m_if.writedata !== 32'h5) $display("FAIL pe_m_writedata got %h exp 5", m_if.writedata); else passed++;
    total++; if (proto_err !== 1'b1) $display("FAIL pe_flag got %b exp 1", proto_err); else passed++;
    total++; if (pending !== 4'd0) $display("FAIL pe_pending got %0d exp 0", pending); else passed++;
    tick();
    total++; if (m_if.write !== 1'b0) $display("FAIL pe_single got %b exp 0", m_if.write); else passed++;
    total++; if (proto_err !== 1'b1) $display("FAIL pe_sticky got %b exp 1", proto_err); else passed++;
  endtask

  task automatic test_reset_inflight;
    m_if.waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_if.read = 1'b1; s_if.address = 28'h000_0200 + 28'(4 * k);
      tick();
    end
    s_if.read = 1'b0;
    total++; if (m_if.read !== 1'b1) $display("FAIL ri_m_read got %b exp 1", m_if.read); else passed++;
    total++; if (m_if.address !== 28'h000_0200) $display("FAIL ri_m_address got %h exp 200", m_if.address); else passed++;
    total++; if (pending !== 4'd3) $display("FAIL ri_pending got %0d exp 3", pending); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_if.waitrequest = 1'b0;
    #1;
    total++; if (m_if.read !== 1'b0) $display("FAIL ri_post_m_read got %b exp 0", m_if.read); else passed++;
    total++; if (pending !== 4'd0) $display("FAIL ri_post_pending got %0d exp 0", pending); else passed++;
    total++; if (s_if.waitrequest !== 1'b0) $display("FAIL ri_post_wait got %b exp 0", s_if.waitrequest); else passed++;
    total++; if ({proto_err, spurious_err} !== 2'b00) $display("FAIL ri_post_flags got %b exp 00", {proto_err, spurious_err}); else passed++;
    tick();
    total++; if ({m_if.read, m_if.write} !== 2'b00) $display("FAIL ri_fifo_empty got %b exp 00", {m_if.read, m_if.write}); else passed++;
    m_if.readdatavalid = 1'b1; m_if.readdata = 32'h1234_5678;
    tick();
    clear_inputs();
    total++; if (spurious_err !== 1'b1) $display("FAIL ri_stale_spur got %b exp 1", spurious_err); else passed++;
    total++; if (s_if.readdatavalid !== 1'b0) $display("FAIL ri_stale_rdv got %b exp 0", s_if.readdatavalid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_reads();
    test_stall();
    test_spurious();
    test_proto();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
